dp_ram_fifo_ctrl: RTL and testbench

FIFO controller that turns the 64x14 simple dual-port RAM (`Memory`) into a streaming valid/ready FIFO. Port 1 of the RAM is used as the write port and port 2 as the read port. The controller absorbs the RAM's two-edge registered read latency (address register, then data register) with a 4-entry output buffer, so it sustains one word per cycle under backpressure. It sits directly upstream of the RAM, instantiated next to it, and supplies every RAM address, write-enable and write-data signal.

---
 rtl/dp_ram_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_dp_ram_fifo_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl: turns a simple dual-port RAM with a two-edge registered read
// (address register, then data register) into a streaming valid/ready FIFO.
// Port A of the RAM is the write port and port B is the read port. A 4-entry
// register buffer on the output absorbs the read latency, so the FIFO keeps
// one word per cycle under backpressure.
//
// Ports
//   clk, rst                       clock; synchronous active-high reset
//   in_data/in_valid/in_ready      write-side stream
//   out_data/out_valid/out_ready   read-side stream (head of the output buffer)
//   level                          words accepted and not yet delivered
//   ram_addr_a/ram_data_in_a/ram_write_en_a   RAM write port
//   ram_addr_b/ram_data_in_b/ram_write_en_b   RAM read port (write side tied off)
//   ram_data_out_b                 RAM read data
module dp_ram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_in_a,
    output logic                  ram_write_en_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_data_in_b,
    output logic                  ram_write_en_b,
    input  logic [DATA_WIDTH-1:0] ram_data_out_b
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
    localparam int unsigned LVL_W     = ADDR_WIDTH + 2;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned BUF_AW    = 2;
    localparam int unsigned BUF_CW    = 3;

    // Architectural state
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      ram_occ_q, ram_occ_d;
    logic [CNT_W-1:0]      unissued_q, unissued_d;
    logic [1:0]            vp_q, vp_d;
    logic [DATA_WIDTH-1:0] buf_mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_mem_d [BUF_DEPTH];
    logic [BUF_AW-1:0]     buf_head_q, buf_head_d;
    logic [BUF_AW-1:0]     buf_tail_q, buf_tail_d;
    logic [BUF_CW-1:0]     buf_count_q, buf_count_d;

    // Per-cycle events
    logic                  push_c;
    logic                  issue_c;
    logic                  land_c;
    logic                  pop_c;
    logic [BUF_CW-1:0]     credit_used_c;

    // Handshakes and RAM port drive
    always_comb begin
        in_ready       = !rst && (ram_occ_q < CNT_W'(DEPTH));
        push_c         = in_valid && in_ready;
        out_valid      = (buf_count_q != '0);
        out_data       = buf_mem_q[buf_head_q];
        pop_c          = out_valid && out_ready;
        level          = LVL_W'(ram_occ_q) + LVL_W'(buf_count_q);

        ram_addr_a     = wr_ptr_q;
        ram_data_in_a  = in_data;
        ram_write_en_a = push_c;
        ram_addr_b     = rd_ptr_q;
        ram_data_in_b  = '0;
        ram_write_en_b = 1'b0;
    end

    // Read issue: reads in flight plus buffered words never exceed the buffer size,
    // so every landing word has a free buffer slot.
    always_comb begin
        credit_used_c = BUF_CW'(vp_q[0]) + BUF_CW'(vp_q[1]) + buf_count_q;
        issue_c       = (unissued_q != '0) && (credit_used_c < BUF_CW'(BUF_DEPTH));
        land_c        = vp_q[1];
    end

    // Next-state: each counter takes the net effect of all events in the cycle
    always_comb begin
        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(push_c);
        rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(issue_c);
        // A slot stays occupied until its word has landed in the buffer
        ram_occ_d   = ram_occ_q + CNT_W'(push_c) - CNT_W'(land_c);
        unissued_d  = unissued_q + CNT_W'(push_c) - CNT_W'(issue_c);
        vp_d        = {vp_q[0], issue_c};
        buf_count_d = buf_count_q + BUF_CW'(land_c) - BUF_CW'(pop_c);
        buf_tail_d  = buf_tail_q + BUF_AW'(land_c);
        buf_head_d  = buf_head_q + BUF_AW'(pop_c);
        buf_mem_d   = buf_mem_q;
        if (land_c) begin
            buf_mem_d[buf_tail_q] = ram_data_out_b;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_occ_q   <= '0;
            unissued_q  <= '0;
            vp_q        <= '0;
            buf_head_q  <= '0;
            buf_tail_q  <= '0;
            buf_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_occ_q   <= ram_occ_d;
            unissued_q  <= unissued_d;
            vp_q        <= vp_d;
            buf_head_q  <= buf_head_d;
            buf_tail_q  <= buf_tail_d;
            buf_count_q <= buf_count_d;
        end
    end

    // Buffer storage needs no reset; buf_count qualifies its contents
    always_ff @(posedge clk) begin
        buf_mem_q <= buf_mem_d;
    end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Self-checking bench for dp_ram_fifo_ctrl with a behavioural model of the
// 64x14 RAM (registered address, then registered data) and a queue scoreboard.
module tb_dp_ram_fifo_ctrl;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 14;
    localparam int unsigned DEPTH = 64;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW+1:0] level;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          we_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic          we_b;
    logic [DW-1:0] dout_b;

    dp_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .ram_addr_a     (addr_a),
        .ram_data_in_a  (din_a),
        .ram_write_en_a (we_a),
        .ram_addr_b     (addr_b),
        .ram_data_in_b  (din_b),
        .ram_write_en_b (we_b),
        .ram_data_out_b (dout_b)
    );

    // RAM model: address register loads at one edge, data register at the next
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr_q;
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        raddr_q <= addr_b;
        dout_b  <= mem[raddr_q];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard: every accepted word not yet delivered, in order
    logic [DW-1:0] exp_q [$];
    int            push_cnt;
    bit            fire_in, fire_out, stall_prev, ir_s, ov_s;
    logic [DW-1:0] prev_data, popped;
    logic [AW+1:0] lvl_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check at the falling edge, update the model at the rising edge
    task automatic step();
        @(negedge clk);
        ir_s  = in_ready;
        ov_s  = out_valid;
        lvl_s = level;
        chk("we_b_zero", 32'(we_b), 0);
        chk("din_b_zero", 32'(din_b), 0);
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 0);
            chk("rst_we_a", 32'(we_a), 0);
        end else begin
            chk("level", 32'(level), 32'(exp_q.size()));
            if (exp_q.size() < DEPTH) chk("in_ready_room", 32'(in_ready), 1);
            if (exp_q.size() >= DEPTH + 4) chk("in_ready_full", 32'(in_ready), 0);
            chk("we_a", 32'(we_a), 32'(in_valid && in_ready));
            if (we_a) begin
                chk("addr_a", 32'(addr_a), 32'(push_cnt % DEPTH));
                chk("din_a", 32'(din_a), 32'(in_data));
            end
            if (exp_q.size() == 0) chk("out_valid_empty", 32'(out_valid), 0);
            else if (out_valid) chk("out_data", 32'(out_data), 32'(exp_q[0]));
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
        end
        fire_in    = !rst && in_valid && in_ready;
        fire_out   = !rst && out_valid && out_ready;
        stall_prev = !rst && out_valid && !out_ready;
        prev_data  = out_data;
        popped     = out_data;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            push_cnt = 0;
        end else begin
            if (fire_out && exp_q.size() > 0) void'(exp_q.pop_front());
            if (fire_in) begin
                exp_q.push_back(in_data);
                push_cnt++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ir;
        logic          we;
        logic [AW-1:0] wa;
        logic          ov;
        logic [DW-1:0] od;
        logic [AW+1:0] lvl;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int pushed, got, rise, npop, first_pop, last_pop, c;

        // iv, id, ordy | in_ready, we_a, addr_a, out_valid, out_data, level
        tbl[0]  = '{1'b1, 14'h2A5, 1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 14'h000, 8'd0};
        tbl[1]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd1};
        tbl[2]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd1};
        tbl[3]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd1};
        tbl[4]  = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 14'h2A5, 8'd1};
        tbl[5]  = '{1'b1, 14'h111, 1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 14'h000, 8'd0};
        tbl[6]  = '{1'b1, 14'h222, 1'b0, 1'b1, 1'b1, 6'd2, 1'b0, 14'h000, 8'd1};
        tbl[7]  = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd2};
        tbl[8]  = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd2};
        tbl[9]  = '{1'b0, 14'h000, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 14'h111, 8'd2};
        tbl[10] = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 14'h111, 8'd2};
        tbl[11] = '{1'b1, 14'h333, 1'b1, 1'b1, 1'b1, 6'd3, 1'b1, 14'h222, 8'd1};
        tbl[12] = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd1};
        tbl[13] = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd1};
        tbl[14] = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd1};
        tbl[15] = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 14'h333, 8'd1};
        tbl[16] = '{1'b0, 14'h000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 14'h000, 8'd0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        push_cnt = 0; stall_prev = 1'b0; prev_data = '0;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_level", 32'(level), 0);
        chk("post_rst_we_a", 32'(we_a), 0);
        chk("post_rst_addr_a", 32'(addr_a), 0);
        chk("post_rst_addr_b", 32'(addr_b), 0);
        @(posedge clk); #1;

        // Cycle-exact vectors: single word latency, hold under stall, push+pop
        for (int i = 0; i < 17; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("vec%0d_we_a", i), 32'(we_a), 32'(tbl[i].we));
            if (tbl[i].we) chk($sformatf("vec%0d_addr_a", i), 32'(addr_a), 32'(tbl[i].wa));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        do_reset();

        // Fill: 64 RAM words plus 4 buffered
        out_ready = 1'b0;
        pushed = 0;
        for (c = 0; c < 400 && pushed < DEPTH + 4; c++) begin
            in_valid = 1'b1;
            in_data  = DW'(pushed);
            step();
            if (fire_in) pushed++;
        end
        in_valid = 1'b0;
        chk("fill_pushed", 32'(pushed), DEPTH + 4);
        step();
        chk("fill_in_ready", 32'(ir_s), 0);
        chk("fill_level", 32'(lvl_s), DEPTH + 4);

        // Drain in order; space reappears once the first popped slot is refilled
        out_ready = 1'b1;
        got = 0; rise = -1;
        for (c = 0; c < 400 && got < DEPTH + 4; c++) begin
            step();
            if (ir_s && rise < 0) rise = c;
            if (fire_out) begin
                chk("drain_order", 32'(popped), 32'(got));
                got++;
            end
        end
        chk("drain_count", 32'(got), DEPTH + 4);
        chk("drain_in_ready_rise", 32'(rise), 4);

        // Streaming across pointer wrap
        pushed = 0; npop = 0; first_pop = -1; last_pop = -1;
        for (c = 0; c < 600 && npop < 200; c++) begin
            in_valid = (pushed < 200);
            in_data  = DW'(32'h100 + 32'(pushed));
            step();
            if (fire_in) pushed++;
            if (fire_out) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                npop++;
            end
        end
        in_valid = 1'b0;
        chk("stream_count", 32'(npop), 200);
        chk("stream_first", 32'(first_pop), 4);
        chk("stream_last", 32'(last_pop), 203);

        // Random backpressure on both sides
        pushed = 0;
        for (c = 0; c < 20000 && (pushed < 1000 || exp_q.size() > 0); c++) begin
            in_valid  = (pushed < 1000) && ($urandom_range(0, 1) == 1);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            step();
            if (fire_in) pushed++;
        end
        in_valid = 1'b0;
        chk("rand_pushed", 32'(pushed), 1000);
        chk("rand_drained", 32'(exp_q.size()), 0);

        // Reset with reads in flight
        out_ready = 1'b0;
        pushed = 0;
        for (c = 0; c < 100 && pushed < 20; c++) begin
            in_valid = 1'b1;
            in_data  = DW'(32'h3000 + 32'(pushed));
            step();
            if (fire_in) pushed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        npop = 0;
        for (c = 0; c < 100 && npop < 5; c++) begin
            step();
            if (fire_out) npop++;
        end
        chk("mid_popped", 32'(npop), 5);
        out_ready = 1'b0;
        do_reset();
        step();
        chk("mid_rst_out_valid", 32'(ov_s), 0);
        chk("mid_rst_level", 32'(lvl_s), 0);
        in_valid = 1'b1;
        in_data  = 14'h1FF;
        for (c = 0; c < 10; c++) begin
            step();
            if (fire_in) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        npop = 0; got = 0;
        for (c = 0; c < 12; c++) begin
            step();
            if (fire_out) begin
                npop++;
                got = int'(popped);
            end
        end
        chk("mid_single_pop", 32'(npop), 1);
        chk("mid_single_data", 32'(got), 32'h1FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
